// File: rtl/spi_sclk_gen.sv
// SPI serial clock generator: divides i_clk into SCLK, emits edge strobes for the
// shift stage and frames each transfer with programmable CS setup/hold delays.
module spi_sclk_gen #(
  parameter int DIV_W = 16,
  parameter int DLY_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_divider,
  input  logic             i_cpol,
  input  logic [DLY_W-1:0] i_cs_setup,
  input  logic [DLY_W-1:0] i_cs_hold,
  input  logic             i_enable,
  input  logic             i_last,
  output logic             o_sclk,
  output logic             o_pos_edge,
  output logic             o_neg_edge,
  output logic             o_cs_active,
  output logic             o_busy,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic             clk_int;
  logic             cpol_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DLY_W-1:0] dly_cnt;

  assign o_state = state;

  // o_sclk is updated alongside clk_int/cpol_q so the pad sees a flop output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      clk_int     <= 1'b0;
      cpol_q      <= 1'b0;
      div_cnt     <= '0;
      dly_cnt     <= '0;
      o_sclk      <= 1'b0;
      o_pos_edge  <= 1'b0;
      o_neg_edge  <= 1'b0;
      o_cs_active <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_pos_edge <= 1'b0;
      o_neg_edge <= 1'b0;
      case (state)
        IDLE: begin
          clk_int     <= 1'b0;
          cpol_q      <= i_cpol;
          o_sclk      <= i_cpol;
          o_cs_active <= 1'b0;
          if (i_enable) begin
            state       <= SETUP;
            dly_cnt     <= i_cs_setup;
            div_cnt     <= i_divider;
            o_cs_active <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        SETUP: begin
          if (dly_cnt == '0) begin
            state <= RUN;
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end
        RUN: begin
          // A pending stop waits for SCLK to be low so the falling half completes.
          if (!i_enable && !clk_int) begin
            state   <= HOLD;
            dly_cnt <= i_cs_hold;
          end else if (div_cnt == '0) begin
            div_cnt <= i_divider;
            if (clk_int) begin
              clk_int    <= 1'b0;
              o_sclk     <= cpol_q;
              o_neg_edge <= 1'b1;
            end else begin
              o_pos_edge <= 1'b1;
              // The terminating strobe on the last bit keeps SCLK idle at the pad.
              if (!i_last) begin
                clk_int <= 1'b1;
                o_sclk  <= ~cpol_q;
              end
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        HOLD: begin
          clk_int <= 1'b0;
          o_sclk  <= cpol_q;
          if (dly_cnt == '0) begin
            state       <= IDLE;
            o_cs_active <= 1'b0;
            o_busy      <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Testbench for spi_sclk_gen: directed transfers; expected strobe and CS events are
// queued by the stimulus and matched by a negedge monitor.
module tb_spi_sclk_gen;

  localparam int DIV_W = 16;
  localparam int DLY_W = 8;
  localparam int W     = 37;  // {busy, sclk, kind[2:0], cycle[31:0]}

  localparam logic [2:0] K_POS  = 3'd1;
  localparam logic [2:0] K_NEG  = 3'd2;
  localparam logic [2:0] K_RISE = 3'd3;
  localparam logic [2:0] K_FALL = 3'd4;

  logic             i_clk;
  logic             i_rst_n;
  logic [DIV_W-1:0] i_divider;
  logic             i_cpol;
  logic [DLY_W-1:0] i_cs_setup;
  logic [DLY_W-1:0] i_cs_hold;
  logic             i_enable;
  logic             i_last;
  logic             o_sclk;
  logic             o_pos_edge;
  logic             o_neg_edge;
  logic             o_cs_active;
  logic             o_busy;
  logic [1:0]       o_state;

  spi_sclk_gen #(.DIV_W(DIV_W), .DLY_W(DLY_W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_divider  (i_divider),
    .i_cpol     (i_cpol),
    .i_cs_setup (i_cs_setup),
    .i_cs_hold  (i_cs_hold),
    .i_enable   (i_enable),
    .i_last     (i_last),
    .o_sclk     (o_sclk),
    .o_pos_edge (o_pos_edge),
    .o_neg_edge (o_neg_edge),
    .o_cs_active(o_cs_active),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [W-1:0] ev(input logic busy, input logic sclk,
                                      input logic [2:0] kind, input int c);
    logic [31:0] cw;
    cw = c;
    return {busy, sclk, kind, cw};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic pop_cmp(input logic [W-1:0] got);
    logic [W-1:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got busy=%0b sclk=%0b kind=%0d cycle=%0d, expected none",
               got[36], got[35], got[34:32], got[31:0]);
      return;
    end
    exp = exp_q.pop_front();
    if (got === exp) n_pass++;
    else $display("FAIL event: got busy=%0b sclk=%0b kind=%0d cycle=%0d, expected busy=%0b sclk=%0b kind=%0d cycle=%0d",
                  got[36], got[35], got[34:32], got[31:0], exp[36], exp[35], exp[34:32], exp[31:0]);
  endtask

  // Monitor: every strobe and every CS edge is an observable output event.
  logic cs_prev = 1'b0;
  always @(negedge i_clk) begin
    if (o_pos_edge || o_neg_edge) begin
      check("strobe_exclusive", {31'd0, o_pos_edge && o_neg_edge}, 32'd0);
      pop_cmp(ev(o_busy, o_sclk, o_pos_edge ? K_POS : K_NEG, cyc));
    end
    if (o_cs_active !== cs_prev)
      pop_cmp(ev(o_busy, o_sclk, o_cs_active ? K_RISE : K_FALL, cyc));
    cs_prev = o_cs_active;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  int e0;
  int r;

  initial begin
    i_rst_n    = 1'b0;
    i_divider  = '0;
    i_cpol     = 1'b1;
    i_cs_setup = '0;
    i_cs_hold  = '0;
    i_enable   = 1'b0;
    i_last     = 1'b0;

    // Reset state, then idle level follows CPOL.
    tick();
    tick();
    check("rst_sclk", o_sclk, 0);
    check("rst_cs", o_cs_active, 0);
    check("rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    tick();
    tick();
    check("idle_sclk_cpol1", o_sclk, 1);
    check("idle_pos", o_pos_edge, 0);
    check("idle_neg", o_neg_edge, 0);
    check("idle_cs", o_cs_active, 0);
    check("idle_busy", o_busy, 0);
    check("idle_state", o_state, 0);

    // 8-bit frame: divider 3, setup 2, hold 5, CPOL 0.
    i_cpol = 1'b0;
    tick();
    i_divider  = 16'd3;
    i_cs_setup = 8'd2;
    i_cs_hold  = 8'd5;
    i_enable   = 1'b1;
    e0 = cyc + 1;
    r  = e0 + 3;
    exp_q.push_back(ev(1, 0, K_RISE, e0));
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(ev(1, 1, K_POS, r + 4 + 8 * k));
      exp_q.push_back(ev(1, 0, K_NEG, r + 8 + 8 * k));
    end
    exp_q.push_back(ev(1, 0, K_POS, r + 68));
    exp_q.push_back(ev(0, 0, K_FALL, r + 75));
    wait_cyc(r + 64);
    i_last = 1'b1;
    wait_cyc(r + 68);
    i_enable = 1'b0;
    i_last   = 1'b0;
    wait_cyc(r + 70);
    check("t2_hold_state", o_state, 3);
    check("t2_hold_cs", o_cs_active, 1);
    check("t2_hold_sclk", o_sclk, 0);
    drain("t2_drain", 20);

    // Divider 0, CPOL 1: strobes alternate every cycle.
    tick();
    i_cpol     = 1'b1;
    i_divider  = 16'd0;
    i_cs_setup = 8'd0;
    i_cs_hold  = 8'd0;
    i_enable   = 1'b1;
    e0 = cyc + 1;
    r  = e0 + 1;
    exp_q.push_back(ev(1, 1, K_RISE, e0));
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ev(1, 0, K_POS, r + 1 + 2 * k));
      exp_q.push_back(ev(1, 1, K_NEG, r + 2 + 2 * k));
    end
    exp_q.push_back(ev(1, 1, K_POS, r + 9));
    exp_q.push_back(ev(0, 1, K_FALL, r + 11));
    wait_cyc(r + 8);
    i_last = 1'b1;
    wait_cyc(r + 9);
    i_enable = 1'b0;
    i_last   = 1'b0;
    drain("t3_drain", 20);

    // Divider 3 -> 1 mid-RUN and a CPOL toggle that must not reach the pad.
    tick();
    i_cpol     = 1'b0;
    i_divider  = 16'd3;
    i_cs_hold  = 8'd1;
    i_enable   = 1'b1;
    e0 = cyc + 1;
    r  = e0 + 1;
    exp_q.push_back(ev(1, 0, K_RISE, e0));
    exp_q.push_back(ev(1, 1, K_POS, r + 4));
    exp_q.push_back(ev(1, 0, K_NEG, r + 6));
    exp_q.push_back(ev(1, 1, K_POS, r + 8));
    exp_q.push_back(ev(1, 0, K_NEG, r + 10));
    exp_q.push_back(ev(1, 0, K_POS, r + 12));
    exp_q.push_back(ev(0, 0, K_FALL, r + 15));
    wait_cyc(r + 1);
    i_divider = 16'd1;
    wait_cyc(r + 4);
    i_cpol = 1'b1;
    wait_cyc(r + 5);
    check("t5_cpol_no_glitch", o_sclk, 1);
    wait_cyc(r + 10);
    i_last = 1'b1;
    wait_cyc(r + 12);
    i_enable = 1'b0;
    i_last   = 1'b0;
    wait_cyc(r + 16);
    check("t5_idle_follows_cpol", o_sclk, 1);
    check("t5_idle_state", o_state, 0);
    drain("t5_drain", 10);

    // Asynchronous reset mid-RUN with SCLK high.
    tick();
    i_cpol    = 1'b0;
    i_divider = 16'd3;
    i_cs_hold = 8'd0;
    i_enable  = 1'b1;
    e0 = cyc + 1;
    r  = e0 + 1;
    exp_q.push_back(ev(1, 0, K_RISE, e0));
    exp_q.push_back(ev(1, 1, K_POS, r + 4));
    exp_q.push_back(ev(0, 0, K_FALL, r + 5));
    wait_cyc(r + 5);
    check("t6_sclk_high", o_sclk, 1);
    #2;
    i_rst_n  = 1'b0;
    i_enable = 1'b0;
    #1;
    check("t6_async_sclk", o_sclk, 0);
    check("t6_async_cs", o_cs_active, 0);
    check("t6_async_busy", o_busy, 0);
    check("t6_async_strobes", {30'd0, o_pos_edge, o_neg_edge}, 0);
    i_cpol = 1'b1;
    wait_cyc(r + 6);
    i_rst_n = 1'b1;
    wait_cyc(r + 7);
    check("t6_post_rst_sclk", o_sclk, 1);
    check("t6_post_rst_busy", o_busy, 0);
    check("t6_post_rst_cs", o_cs_active, 0);
    drain("t6_drain", 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
SCLK generator directly upstream of the SPI shift register stage.
- Divides i_clk to produce the serial clock.
- Emits single-cycle rising/falling strobes that the shift stage uses to shift, sample and count bits.
- Frames each transfer with a programmable chip-select setup and hold delay.
- Runs while the shift stage's transfer-in-progress flag (wired to i_enable) is high.
- Stops cleanly on the shift stage's last-bit flag (wired to i_last).

Parameters:
DIV_W, 16, width of the half-period divider.
DLY_W, 8, width of the CS setup/hold delay counters.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset; asynchronous, active-low
i_divider  input  DIV_W  half SCLK period = i_divider+1 i_clk cycles
i_cpol  input  1  SCLK idle level
i_cs_setup  input  DLY_W  i_clk cycles between CS assert and first SCLK half-period start
i_cs_hold  input  DLY_W  i_clk cycles between final SCLK edge and CS release
i_enable  input  1  transfer in progress (from shift stage)
i_last  input  1  last bit in flight (from shift stage)
o_sclk  output  1  serial clock to pad
o_pos_edge  output  1  1-cycle strobe, internal clock rising (CPOL-independent)
o_neg_edge  output  1  1-cycle strobe, internal clock falling
o_cs_active  output  1  chip-select active (active-high; polarity at top level)
o_busy  output  1  state != IDLE

Behaviour:
Reset values:
- state=IDLE, clk_int=0, cpol_q=0, div_cnt=0, dly_cnt=0.
- o_sclk=0, o_pos_edge=0, o_neg_edge=0, o_cs_active=0, o_busy=0.
- Reset is asynchronous and valid mid-transfer: all outputs return to reset values immediately, with no completion of the frame.

Output encoding:
- All outputs are registered.
- o_sclk = clk_int XOR cpol_q.
- cpol_q is loaded from i_cpol only on the IDLE->SETUP transition. In IDLE, cpol_q tracks i_cpol every cycle so the idle level follows configuration.

IDLE:
- clk_int=0, o_cs_active=0.
- i_enable=1 -> SETUP, with dly_cnt<=i_cs_setup, o_cs_active<=1, div_cnt<=i_divider.

SETUP:
- If dly_cnt==0 -> RUN, else dly_cnt-1.
- i_cs_setup=0 therefore still costs exactly 1 cycle in SETUP.

RUN:
- div_cnt decrements each cycle.
- At div_cnt==0 (half-period expiry): div_cnt<=i_divider. i_divider is sampled only at reload; mid-transfer changes take effect on the next half-period.
- Expiry with clk_int==1: clk_int<=0, o_neg_edge<=1 for that cycle.
- Expiry with clk_int==0 and i_last==0: clk_int<=1, o_pos_edge<=1.
- Expiry with clk_int==0 and i_last==1: o_pos_edge<=1, clk_int stays 0. This is the terminating strobe; no extra SCLK pulse reaches the pad.
- i_enable==0 observed while clk_int==0 -> HOLD, with dly_cnt<=i_cs_hold, no strobe.
- If i_enable falls while clk_int==1, the block first completes the falling half-period, including its o_neg_edge, then enters HOLD.
- o_pos_edge and o_neg_edge are never high in the same cycle.

HOLD:
- clk_int=0, no strobes.
- dly_cnt==0 -> IDLE with o_cs_active<=0, else dly_cnt-1.
- i_enable is ignored in HOLD. If i_enable is high on arrival in IDLE, a new SETUP starts the following cycle, so o_cs_active deasserts for at least 1 cycle between frames.

Timing:
- First strobe (o_pos_edge) asserts i_divider+1 cycles after entering RUN.
- With i_divider=0, clk_int toggles every i_clk cycle and strobes alternate every cycle.

Counters:
- All counters are unsigned and do not wrap: decrement happens only when nonzero, reload happens at zero.

Test Plan:
- Reset, then idle with i_cpol=1 -> o_sclk=1; all strobes, o_cs_active and o_busy = 0.
- i_divider=3, i_cs_setup=2, i_cpol=0, pulse i_enable high for 8 bits with i_last asserted during bit 8 -> o_cs_active rises 1 cycle after i_enable; first o_pos_edge 3+4=7 cycles after that; o_pos_edge spacing 8 cycles; 8 SCLK high pulses of 4 cycles each; 9th o_pos_edge (terminating) with o_sclk held 0.
- i_divider=0 -> o_sclk toggles every cycle; o_pos_edge and o_neg_edge alternate and are never coincident.
- i_cs_hold=5, drop i_enable after the terminating strobe -> o_cs_active stays high 6 cycles after entering HOLD (5 counts plus the exit cycle); o_busy falls in the same cycle.
- Change i_divider from 3 to 1 mid-RUN -> the current half-period completes at 4 cycles, subsequent half-periods are 2 cycles; i_cpol toggled mid-RUN -> o_sclk shows no glitch.
- Assert i_rst_n=0 mid-RUN with o_sclk high -> all outputs 0 asynchronously (before the next i_clk edge); after release, IDLE with o_sclk = i_cpol on the next cycle.
